// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART TX arbiter.
// State encodings are fixed so debug probes can decode the FSM directly.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_t;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Channel index width; covers the supported 2..8 channels.
  localparam int IDX_W = 3;

endpackage

// File: rtl/uart_arb_pick.sv
// Combinational winner picker: fixed priority (lowest index) or
// round-robin (first requester after ptr, wrapping).
module uart_arb_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NCH = 4
) (
  input  logic [NCH-1:0]   req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             mode,
  output logic [NCH-1:0]   win_onehot,
  output logic [IDX_W-1:0] win_idx,
  output logic             win_valid
);

  logic [NCH-1:0] rot;
  int             base;

  always_comb begin
    // rot[j] is the request of the channel searched j-th; fixed mode starts at 0.
    base = mode ? ((int'(ptr) + 1) % NCH) : 0;
    rot  = '0;
    for (int j = 0; j < NCH; j++) begin
      for (int c = 0; c < NCH; c++) begin
        if (c == ((base + j) % NCH)) rot[j] = req[c];
      end
    end

    win_valid = 1'b0;
    win_idx   = '0;
    for (int j = 0; j < NCH; j++) begin
      if (!win_valid && rot[j]) begin
        win_valid = 1'b1;
        win_idx   = IDX_W'((base + j) % NCH);
      end
    end

    win_onehot = '0;
    for (int c = 0; c < NCH; c++) begin
      win_onehot[c] = win_valid && (win_idx == IDX_W'(c));
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Frame-atomic arbiter sharing one uart_tx between NCH print sources;
// non-owners are held off through their own busy line.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NCH            = 4,
  parameter int ARB_MODE       = 0,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int CNT_W          = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   req,
  input  logic [NCH-1:0]   src_tx_en,
  input  logic [8*NCH-1:0] src_tx_data,
  input  logic [NCH-1:0]   src_done,
  input  logic             uart_tx_busy,
  output logic [NCH-1:0]   src_tx_busy,
  output logic             uart_tx_en,
  output logic [7:0]       uart_tx_data,
  output logic [NCH-1:0]   grant,
  output logic [2:0]       owner_idx,
  output logic             timeout_err,
  output logic [2:0]       err_ch
);

  localparam bit               WD_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(WD_EN ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic             RR_MODE = (ARB_MODE == ARB_RR);

  arb_state_t       state_reg, state_next;
  logic [NCH-1:0]   grant_reg, grant_next;
  logic [IDX_W-1:0] owner_idx_reg, owner_idx_next;
  logic [IDX_W-1:0] rr_ptr_reg, rr_ptr_next;
  logic [IDX_W-1:0] err_ch_reg, err_ch_next;
  logic [CNT_W-1:0] wd_cnt_reg, wd_cnt_next;
  logic             timeout_err_reg, timeout_err_next;

  logic [NCH-1:0]   win_onehot;
  logic [IDX_W-1:0] win_idx;
  logic             win_valid;
  logic             own_strobe, own_done, own_req;
  logic [7:0]       data_mux;

  uart_arb_pick #(.NCH(NCH)) u_pick (
    .req        (req),
    .ptr        (rr_ptr_reg),
    .mode       (RR_MODE),
    .win_onehot (win_onehot),
    .win_idx    (win_idx),
    .win_valid  (win_valid)
  );

  // grant_reg is non-zero only in GRANT, so masking by it gates the whole data path.
  assign own_strobe = |(grant_reg & src_tx_en);
  assign own_done   = |(grant_reg & src_done);
  assign own_req    = |(grant_reg & req);

  for (genvar gi = 0; gi < NCH; gi++) begin : g_busy
    assign src_tx_busy[gi] = grant_reg[gi] ? uart_tx_busy : 1'b1;
  end

  always_comb begin
    data_mux = '0;
    for (int k = 0; k < NCH; k++) begin
      if (grant_reg[k]) data_mux = data_mux | src_tx_data[8*k +: 8];
    end
  end

  assign uart_tx_en   = own_strobe;
  assign uart_tx_data = data_mux;
  assign grant        = grant_reg;
  assign owner_idx    = owner_idx_reg;
  assign timeout_err  = timeout_err_reg;
  assign err_ch       = err_ch_reg;

  always_comb begin
    state_next       = state_reg;
    grant_next       = grant_reg;
    owner_idx_next   = owner_idx_reg;
    rr_ptr_next      = rr_ptr_reg;
    err_ch_next      = err_ch_reg;
    wd_cnt_next      = wd_cnt_reg;
    timeout_err_next = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (win_valid) begin
          state_next     = ST_GRANT;
          grant_next     = win_onehot;
          owner_idx_next = win_idx;
          wd_cnt_next    = '0;
          if (ARB_MODE != ARB_FIXED) rr_ptr_next = win_idx;
        end
      end
      ST_GRANT: begin
        wd_cnt_next = (own_strobe || !WD_EN) ? '0 : wd_cnt_reg + 1'b1;
        // A done in the same cycle as the timeout wins and suppresses the error.
        if (own_done || !own_req) begin
          state_next = ST_DRAIN;
          grant_next = '0;
        end else if (WD_EN && !own_strobe && (wd_cnt_reg == WD_LAST)) begin
          state_next       = ST_DRAIN;
          grant_next       = '0;
          timeout_err_next = 1'b1;
          err_ch_next      = owner_idx_reg;
        end
      end
      ST_DRAIN: begin
        if (!uart_tx_busy) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      grant_reg       <= '0;
      owner_idx_reg   <= '0;
      rr_ptr_reg      <= IDX_W'(NCH - 1);
      err_ch_reg      <= '0;
      wd_cnt_reg      <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      grant_reg       <= grant_next;
      owner_idx_reg   <= owner_idx_next;
      rr_ptr_reg      <= rr_ptr_next;
      err_ch_reg      <= err_ch_next;
      wd_cnt_reg      <= wd_cnt_next;
      timeout_err_reg <= timeout_err_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a fixed-priority instance with a
// 100-cycle watchdog and a round-robin instance share the same stimulus.
module tb_uart_tx_arbiter;

  localparam logic [31:0] DATA = 32'h41_5A_A5_C3;  // ch3..ch0 bytes

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  src_tx_en;
  logic [31:0] src_tx_data;
  logic [3:0]  src_done;
  logic        uart_tx_busy;

  logic [3:0] busy_f, grant_f, busy_r, grant_r;
  logic       uen_f, terr_f, uen_r, terr_r;
  logic [7:0] udata_f, udata_r;
  logic [2:0] owner_f, errch_f, owner_r, errch_r;

  int checks = 0;
  int failures = 0;

  logic     rec = 1'b0;
  bit [7:0] rr_q[$];

  typedef struct packed {
    logic [3:0] req;
    logic [3:0] en;
    logic [3:0] done;
    logic       ubusy;
    logic [3:0] grant;
    logic [2:0] owner;
    logic [3:0] sbusy;
    logic       uen;
    logic [7:0] udata;
  } vec_t;

  vec_t tbl[16];

  uart_tx_arbiter #(.NCH(4), .ARB_MODE(0), .TIMEOUT_CYCLES(100), .CNT_W(26)) dut_fix (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .src_tx_en    (src_tx_en),
    .src_tx_data  (src_tx_data),
    .src_done     (src_done),
    .uart_tx_busy (uart_tx_busy),
    .src_tx_busy  (busy_f),
    .uart_tx_en   (uen_f),
    .uart_tx_data (udata_f),
    .grant        (grant_f),
    .owner_idx    (owner_f),
    .timeout_err  (terr_f),
    .err_ch       (errch_f)
  );

  uart_tx_arbiter #(.NCH(4), .ARB_MODE(1), .TIMEOUT_CYCLES(0), .CNT_W(26)) dut_rr (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .src_tx_en    (src_tx_en),
    .src_tx_data  (src_tx_data),
    .src_done     (src_done),
    .uart_tx_busy (uart_tx_busy),
    .src_tx_busy  (busy_r),
    .uart_tx_en   (uen_r),
    .uart_tx_data (udata_r),
    .grant        (grant_r),
    .owner_idx    (owner_r),
    .timeout_err  (terr_r),
    .err_ch       (errch_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rec && uen_r) rr_q.push_back(udata_r);
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("ok   %s value=%0h", name, act);
    end
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    req          = '0;
    src_tx_en    = '0;
    src_done     = '0;
    src_tx_data  = DATA;
    uart_tx_busy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int bad;
    vec_t v;

    //         req      en       done     ub    grant    own   sbusy    uen   udata
    tbl[0]  = {4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 3'd0, 4'b1111, 1'b0, 8'h00};
    tbl[1]  = {4'b0110, 4'b0000, 4'b0000, 1'b0, 4'b0000, 3'd0, 4'b1111, 1'b0, 8'h00};
    tbl[2]  = {4'b0110, 4'b0100, 4'b0000, 1'b0, 4'b0010, 3'd1, 4'b1101, 1'b0, 8'h00};
    tbl[3]  = {4'b0110, 4'b0010, 4'b0000, 1'b1, 4'b0010, 3'd1, 4'b1111, 1'b1, 8'hA5};
    tbl[4]  = {4'b0110, 4'b0010, 4'b0010, 1'b0, 4'b0010, 3'd1, 4'b1101, 1'b1, 8'hA5};
    tbl[5]  = {4'b0110, 4'b0000, 4'b0000, 1'b1, 4'b0000, 3'd0, 4'b1111, 1'b0, 8'h00};
    tbl[6]  = {4'b0110, 4'b0010, 4'b0000, 1'b0, 4'b0000, 3'd0, 4'b1111, 1'b0, 8'h00};
    tbl[7]  = {4'b0110, 4'b0000, 4'b0000, 1'b0, 4'b0000, 3'd0, 4'b1111, 1'b0, 8'h00};
    tbl[8]  = {4'b0100, 4'b0000, 4'b0000, 1'b0, 4'b0010, 3'd1, 4'b1101, 1'b0, 8'h00};
    tbl[9]  = {4'b0100, 4'b0000, 4'b0000, 1'b0, 4'b0000, 3'd0, 4'b1111, 1'b0, 8'h00};
    tbl[10] = {4'b0100, 4'b0000, 4'b0000, 1'b0, 4'b0000, 3'd0, 4'b1111, 1'b0, 8'h00};
    tbl[11] = {4'b1100, 4'b1000, 4'b0000, 1'b0, 4'b0100, 3'd2, 4'b1011, 1'b0, 8'h00};
    tbl[12] = {4'b1100, 4'b0100, 4'b0100, 1'b0, 4'b0100, 3'd2, 4'b1011, 1'b1, 8'h5A};
    tbl[13] = {4'b1000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 3'd0, 4'b1111, 1'b0, 8'h00};
    tbl[14] = {4'b1000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 3'd0, 4'b1111, 1'b0, 8'h00};
    tbl[15] = {4'b1000, 4'b1000, 4'b0000, 1'b1, 4'b1000, 3'd3, 4'b1111, 1'b1, 8'h41};

    // Table: fixed priority, isolation, done/req-drop exits, drain.
    do_reset();
    chk("reset_grant", grant_f, 4'b0000);
    chk("reset_owner", owner_f, 3'd0);
    chk("reset_errch", errch_f, 3'd0);
    chk("reset_busy", busy_f, 4'b1111);
    for (int i = 0; i < 16; i++) begin
      v            = tbl[i];
      req          = v.req;
      src_tx_en    = v.en;
      src_done     = v.done;
      uart_tx_busy = v.ubusy;
      @(negedge clk);
      chk($sformatf("vec%0d_grant", i), grant_f, v.grant);
      chk($sformatf("vec%0d_sbusy", i), busy_f, v.sbusy);
      chk($sformatf("vec%0d_uen", i), uen_f, v.uen);
      chk($sformatf("vec%0d_terr", i), terr_f, 1'b0);
      if (v.grant != 0) chk($sformatf("vec%0d_owner", i), owner_f, v.owner);
      if (v.uen) chk($sformatf("vec%0d_udata", i), udata_f, v.udata);
      @(posedge clk);
      #1;
    end

    // Round-robin: ch0 and ch1 alternate, 3 bytes per frame.
    do_reset();
    req = 4'b0011;
    rec = 1'b1;
    for (int f = 0; f < 4; f++) begin
      n = 0;
      while (grant_r == 4'b0000 && n < 20) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk($sformatf("rr_frame%0d_grant", f), grant_r, 4'(1 << (f % 2)));
      chk($sformatf("rr_frame%0d_owner", f), owner_r, 3'(f % 2));
      for (int b = 0; b < 3; b++) begin
        src_tx_data = 32'hEEEE_EEEE;
        src_tx_data[8*(f%2) +: 8] = 8'(8'h30 + f*4 + b);
        src_tx_en = 4'b0011;
        src_done  = (b == 2) ? 4'(1 << (f % 2)) : 4'b0000;
        @(posedge clk);
        #1;
      end
      src_tx_en = '0;
      src_done  = '0;
    end
    req = '0;
    @(posedge clk);
    #1;
    rec = 1'b0;
    chk("rr_strobe_count", rr_q.size(), 12);
    for (int i = 0; i < rr_q.size() && i < 12; i++) begin
      chk($sformatf("rr_byte%0d", i), rr_q[i], 8'(8'h30 + (i/3)*4 + (i%3)));
    end

    // Watchdog: ch2 idles after grant, forced release 100 cycles later.
    do_reset();
    req = 4'b0100;
    @(posedge clk);
    #1;
    chk("wd_grant", grant_f, 4'b0100);
    n = 0;
    while (n < 150) begin
      @(posedge clk);
      #1;
      n++;
      if (terr_f) break;
    end
    chk("wd_cycles", n, 100);
    chk("wd_err_ch", errch_f, 3'd2);
    chk("wd_grant_released", grant_f, 4'b0000);
    @(posedge clk);
    #1;
    chk("wd_pulse_width", terr_f, 1'b0);
    req = '0;

    // Drain: done while uart_tx_busy stays high for 50 cycles.
    do_reset();
    req = 4'b1001;
    @(posedge clk);
    #1;
    chk("drain_grant", grant_f, 4'b0001);
    src_tx_en    = 4'b1001;
    src_done     = 4'b0001;
    uart_tx_busy = 1'b1;
    @(negedge clk);
    chk("iso_data", udata_f, 8'hC3);
    chk("iso_ch3_busy", busy_f[3], 1'b1);
    @(posedge clk);
    #1;
    src_tx_en = '0;
    src_done  = '0;
    req       = 4'b0001;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (grant_f != 4'b0000 || busy_f != 4'b1111) bad++;
      @(posedge clk);
      #1;
    end
    chk("drain_hold_bad_cycles", bad, 0);
    uart_tx_busy = 1'b0;
    @(posedge clk);
    #1;
    chk("drain_regrant_1clk", grant_f, 4'b0000);
    @(posedge clk);
    #1;
    chk("drain_regrant_2clk", grant_f, 4'b0001);

    // Asynchronous reset mid-frame.
    do_reset();
    req = 4'b0010;
    @(posedge clk);
    #1;
    chk("rst_pre_grant", grant_f, 4'b0010);
    src_tx_en = 4'b0010;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_grant", grant_f, 4'b0000);
    chk("rst_async_busy_f", busy_f, 4'b1111);
    chk("rst_async_busy_r", busy_r, 4'b1111);
    chk("rst_async_uen", uen_f, 1'b0);
    src_tx_en = '0;
    req       = 4'b1000;
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (grant_f == 4'b0000 && n < 2) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("rst_regrant", grant_f, 4'b1000);
    chk("rst_regrant_owner", owner_f, 3'd3);
    req = '0;

    chk("rr_no_timeout", terr_r, 1'b0);
    chk("rr_errch", errch_r, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
